uart_tx_arbiter: RTL and testbench

- Parametrised N-channel successor to the two-way tx_data/tx_ready select muxes in the UART string datapath.
- Arbitrates ownership of one UART transmitter among N_CH string sources (TX_STRING-style) using round-robin.
- A grant is held for a whole string, not a single byte.
- Routes tx_done back only to the owning channel, and drains any in-flight byte before releasing, so the top-level FSM no longer drives select lines by hand.

---
 rtl/uart_tx_arbiter_if.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between N string sources, the shared UART transmitter and the
// round-robin arbiter that hands the transmitter to one source at a time.
interface uart_tx_arbiter_if #(
  parameter int N_CH   = 4,
  parameter int IDX_W  = 2,
  parameter int DATA_W = 8
);
  // Handshake: req[i] is held high for a whole string. While channel i owns
  // the transmitter, ch_tx_ready[i] marks a valid byte on its ch_tx_data slot;
  // the byte is in flight from the edge that sees tx_ready high until the
  // UART pulses tx_done, which is returned only on ch_tx_done[owner].
  logic [N_CH-1:0]        req;
  logic [N_CH*DATA_W-1:0] ch_tx_data;
  logic [N_CH-1:0]        ch_tx_ready;
  logic [N_CH-1:0]        ch_tx_done;
  logic [DATA_W-1:0]      tx_data;
  logic                   tx_ready;
  logic                   tx_done;
  logic [N_CH-1:0]        grant;
  logic                   grant_valid;
  logic [IDX_W-1:0]       grant_idx;
  logic [1:0]             dbg_state;

  modport slave (
    input  req, ch_tx_data, ch_tx_ready, tx_done,
    output ch_tx_done, tx_data, tx_ready, grant, grant_valid, grant_idx, dbg_state
  );

  modport master (
    output req, ch_tx_data, ch_tx_ready, tx_done,
    input  ch_tx_done, tx_data, tx_ready, grant, grant_valid, grant_idx, dbg_state
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of one UART transmitter among N_CH string sources; the
// grant is held for a whole string and an in-flight byte drains before release.
module uart_tx_arbiter #(
  parameter int N_CH   = 4,
  parameter int IDX_W  = 2,
  parameter int DATA_W = 8
) (
  input logic             clock,
  input logic             reset,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  g_idx, g_idx_nxt;
  logic [IDX_W-1:0]  last_idx, last_idx_nxt;
  logic [IDX_W-1:0]  sel_idx;
  logic              busy, busy_nxt;
  logic              found;
  logic              own_req;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_data;
  logic              owned;

  // Owner-side view of the channel buses, selected by the registered index.
  always_comb begin
    sel_data  = '0;
    sel_ready = 1'b0;
    own_req   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (IDX_W'(i) == g_idx) begin
        sel_data  = bus.ch_tx_data[i*DATA_W +: DATA_W];
        sel_ready = bus.ch_tx_ready[i];
        own_req   = bus.req[i];
      end
    end
  end

  // First requester strictly after the previous owner, wrapping modulo N_CH.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int off = 1; off <= N_CH; off++) begin
      for (int i = 0; i < N_CH; i++) begin
        if (!found && bus.req[i] && (i == (int'(last_idx) + off) % N_CH)) begin
          found   = 1'b1;
          sel_idx = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      g_idx    <= '0;
      last_idx <= IDX_W'(N_CH - 1);
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      g_idx    <= g_idx_nxt;
      last_idx <= last_idx_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    g_idx_nxt    = g_idx;
    last_idx_nxt = last_idx;
    busy_nxt     = busy;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (found) begin
          g_idx_nxt    = sel_idx;
          last_idx_nxt = sel_idx;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        // tx_done wins over a new tx_ready on the same edge.
        if (bus.tx_done)    busy_nxt = 1'b0;
        else if (sel_ready) busy_nxt = 1'b1;
        if (!own_req) state_nxt = busy_nxt ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (bus.tx_done) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign owned = (state != IDLE) && !reset;

  always_comb begin
    bus.tx_data     = owned ? sel_data : '0;
    bus.tx_ready    = (state == GRANT) && !reset && sel_ready;
    bus.grant_valid = (state != IDLE);
    bus.grant_idx   = g_idx;
    bus.dbg_state   = state;
    bus.ch_tx_done  = '0;
    bus.grant       = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.ch_tx_done[i] = owned && bus.tx_done && (IDX_W'(i) == g_idx);
      bus.grant[i]      = (state != IDLE) && (IDX_W'(i) == g_idx);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios on a 4-channel instance,
// round-robin order on 2- and 8-channel instances, and a random model check.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DW = 8;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic clock;
  logic reset;
  int   errors;
  int   checks;
  logic [7:0] exp_q[$];

  uart_tx_arbiter_if #(.N_CH(N), .IDX_W(IW), .DATA_W(DW)) bus ();
  uart_tx_arbiter_if #(.N_CH(2), .IDX_W(1),  .DATA_W(DW)) bus2 ();
  uart_tx_arbiter_if #(.N_CH(8), .IDX_W(3),  .DATA_W(DW)) bus8 ();

  uart_tx_arbiter #(.N_CH(N), .IDX_W(IW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  uart_tx_arbiter #(.N_CH(2), .IDX_W(1), .DATA_W(DW)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2)
  );
  uart_tx_arbiter #(.N_CH(8), .IDX_W(3), .DATA_W(DW)) dut8 (
    .clock(clock), .reset(reset), .bus(bus8)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_byte(input int ch, input logic [7:0] b);
    bus.ch_tx_data[ch*DW +: DW] = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = 4'b1111;
    repeat (3) cyc();
    bus.tx_done = 1'b1;
    bus.ch_tx_ready = 4'b1111;
    #1;
    checks++; if (bus.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.grant_valid); end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b want 0", bus.tx_ready); end
    checks++; if (bus.ch_tx_done !== 4'b0000) begin errors++; $display("FAIL reset_ch_tx_done: got %b want 0000", bus.ch_tx_done); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    bus.tx_done = 1'b0;
    bus.ch_tx_ready = 4'b0000;
    reset = 1'b0;
    cyc();
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", bus.grant); end
    checks++; if (bus.grant_idx !== 2'd0) begin errors++; $display("FAIL reset_first_idx: got %0d want 0", bus.grant_idx); end
    checks++; if (bus.dbg_state !== ST_GRANT) begin errors++; $display("FAIL reset_first_state: got %0d want %0d", bus.dbg_state, ST_GRANT); end
    bus.req = 4'b0000;
    cyc();
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL reset_release: got %b want 0", bus.grant_valid); end
  endtask

  task automatic test_single();
    set_byte(0, 8'hA5);
    set_byte(2, 8'h48);
    bus.req = 4'b0100;
    cyc();
    checks++; if (bus.grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", bus.grant); end
    checks++; if (bus.grant_idx !== 2'd2) begin errors++; $display("FAIL single_idx: got %0d want 2", bus.grant_idx); end
    for (int b = 0; b < 2; b++) begin
      set_byte(2, (b == 0) ? 8'h48 : 8'h69);
      bus.ch_tx_ready = 4'b0101;
      #1;
      checks++; if (bus.tx_data !== ((b == 0) ? 8'h48 : 8'h69)) begin errors++; $display("FAIL single_data%0d: got %h want %h", b, bus.tx_data, (b == 0) ? 8'h48 : 8'h69); end
      checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL single_ready%0d: got %b want 1", b, bus.tx_ready); end
      cyc();
      bus.ch_tx_ready = 4'b0000;
      repeat (2) cyc();
      bus.tx_done = 1'b1;
      #1;
      checks++; if (bus.ch_tx_done !== 4'b0100) begin errors++; $display("FAIL single_done%0d: got %b want 0100", b, bus.ch_tx_done); end
      cyc();
      bus.tx_done = 1'b0;
      #1;
      checks++; if (bus.ch_tx_done !== 4'b0000) begin errors++; $display("FAIL single_done_clear%0d: got %b want 0000", b, bus.ch_tx_done); end
    end
    bus.req = 4'b0000;
    cyc();
    checks++; if (bus.dbg_state !== ST_IDLE) begin errors++; $display("FAIL single_idle: got %0d want %0d", bus.dbg_state, ST_IDLE); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL single_idle_data: got %h want 00", bus.tx_data); end
  endtask

  task automatic test_round_robin();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.req = 4'b1010;
    cyc();
    checks++; if (bus.grant_idx !== 2'd1 || bus.grant !== 4'b0010) begin errors++; $display("FAIL rr_first: got %0d/%b want 1/0010", bus.grant_idx, bus.grant); end
    bus.req = 4'b1000;
    cyc();
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL rr_gap: got %b want 0", bus.grant_valid); end
    checks++; if (bus.tx_ready !== 1'b0 || bus.tx_data !== 8'h00) begin errors++; $display("FAIL rr_gap_out: got %b/%h want 0/00", bus.tx_ready, bus.tx_data); end
    bus.req = 4'b1010;
    cyc();
    checks++; if (bus.grant_idx !== 2'd3 || bus.grant !== 4'b1000) begin errors++; $display("FAIL rr_second: got %0d/%b want 3/1000", bus.grant_idx, bus.grant); end
    bus.req = 4'b0010;
    cyc();
    checks++; if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL rr_gap2: got %b want 0", bus.grant_valid); end
    cyc();
    checks++; if (bus.grant_idx !== 2'd1 || bus.grant !== 4'b0010) begin errors++; $display("FAIL rr_third: got %0d/%b want 1/0010", bus.grant_idx, bus.grant); end
    bus.req = 4'b0000;
    cyc();
  endtask

  task automatic test_drain();
    bus.req = 4'b0001;
    cyc();
    checks++; if (bus.grant !== 4'b0001) begin errors++; $display("FAIL drain_grant: got %b want 0001", bus.grant); end
    set_byte(0, 8'h55);
    bus.ch_tx_ready = 4'b0001;
    #1;
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL drain_ready: got %b want 1", bus.tx_ready); end
    cyc();
    bus.ch_tx_ready = 4'b0000;
    bus.req = 4'b0000;
    cyc();
    bus.ch_tx_ready = 4'b0001;
    bus.req = 4'b0001;
    #1;
    checks++; if (bus.dbg_state !== ST_DRAIN) begin errors++; $display("FAIL drain_state: got %0d want %0d", bus.dbg_state, ST_DRAIN); end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL drain_ready_forced: got %b want 0", bus.tx_ready); end
    checks++; if (bus.grant !== 4'b0001 || bus.grant_valid !== 1'b1) begin errors++; $display("FAIL drain_grant_held: got %b/%b want 0001/1", bus.grant, bus.grant_valid); end
    checks++; if (bus.tx_data !== 8'h55) begin errors++; $display("FAIL drain_data: got %h want 55", bus.tx_data); end
    repeat (9) cyc();
    checks++; if (bus.dbg_state !== ST_DRAIN) begin errors++; $display("FAIL drain_wait: got %0d want %0d", bus.dbg_state, ST_DRAIN); end
    bus.tx_done = 1'b1;
    #1;
    checks++; if (bus.ch_tx_done !== 4'b0001) begin errors++; $display("FAIL drain_done: got %b want 0001", bus.ch_tx_done); end
    cyc();
    bus.tx_done = 1'b0;
    #1;
    checks++; if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0) begin errors++; $display("FAIL drain_release: got %b/%b want 0000/0", bus.grant, bus.grant_valid); end
    checks++; if (bus.tx_ready !== 1'b0 || bus.tx_data !== 8'h00) begin errors++; $display("FAIL drain_idle_out: got %b/%h want 0/00", bus.tx_ready, bus.tx_data); end
    cyc();
    checks++; if (bus.grant_idx !== 2'd0 || bus.grant_valid !== 1'b1) begin errors++; $display("FAIL drain_regrant: got %0d/%b want 0/1", bus.grant_idx, bus.grant_valid); end
    bus.ch_tx_ready = 4'b0000;
    bus.req = 4'b0000;
    cyc();
    checks++; if (bus.dbg_state !== ST_IDLE) begin errors++; $display("FAIL drain_end: got %0d want %0d", bus.dbg_state, ST_IDLE); end
  endtask

  task automatic test_simultaneous();
    bus.req = 4'b0100;
    cyc();
    bus.ch_tx_ready = 4'b0100;
    cyc();
    bus.ch_tx_ready = 4'b0000;
    bus.req = 4'b0000;
    bus.tx_done = 1'b1;
    #1;
    checks++; if (bus.ch_tx_done !== 4'b0100) begin errors++; $display("FAIL simul_done: got %b want 0100", bus.ch_tx_done); end
    cyc();
    checks++; if (bus.dbg_state !== ST_IDLE || bus.grant_valid !== 1'b0) begin errors++; $display("FAIL simul_no_drain: got %0d/%b want %0d/0", bus.dbg_state, bus.grant_valid, ST_IDLE); end
    checks++; if (bus.ch_tx_done !== 4'b0000) begin errors++; $display("FAIL simul_idle_done: got %b want 0000", bus.ch_tx_done); end
    bus.tx_done = 1'b0;
    bus.req = 4'b1000;
    cyc();
    checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL simul_grant3: got %b want 1000", bus.grant); end
    bus.ch_tx_ready = 4'b1000;
    bus.tx_done = 1'b1;
    bus.req = 4'b0000;
    cyc();
    bus.ch_tx_ready = 4'b0000;
    bus.tx_done = 1'b0;
    #1;
    checks++; if (bus.dbg_state !== ST_IDLE) begin errors++; $display("FAIL simul_ready_done: got %0d want %0d", bus.dbg_state, ST_IDLE); end
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b1000;
    cyc();
    checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL rmid_grant: got %b want 1000", bus.grant); end
    bus.ch_tx_ready = 4'b1000;
    cyc();
    bus.ch_tx_ready = 4'b0000;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.req = 4'b0000;
    bus.tx_done = 1'b1;
    #1;
    checks++; if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0) begin errors++; $display("FAIL rmid_clear: got %b/%b want 0000/0", bus.grant, bus.grant_valid); end
    checks++; if (bus.ch_tx_done !== 4'b0000) begin errors++; $display("FAIL rmid_stale_done: got %b want 0000", bus.ch_tx_done); end
    checks++; if (bus.tx_ready !== 1'b0 || bus.tx_data !== 8'h00) begin errors++; $display("FAIL rmid_out: got %b/%h want 0/00", bus.tx_ready, bus.tx_data); end
    cyc();
    bus.tx_done = 1'b0;
    #1;
    checks++; if (bus.dbg_state !== ST_IDLE) begin errors++; $display("FAIL rmid_idle: got %0d want %0d", bus.dbg_state, ST_IDLE); end
    bus.req = 4'b1001;
    cyc();
    checks++; if (bus.grant_idx !== 2'd0) begin errors++; $display("FAIL rmid_last_idx: got %0d want 0", bus.grant_idx); end
    bus.req = 4'b0000;
    cyc();
  endtask

  task automatic test_widths();
    int w;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus2.req = '1;
    bus8.req = '1;
    exp_q.delete();
    for (int k = 0; k <= 2; k++) exp_q.push_back(8'(k % 2));
    while (exp_q.size() > 0) begin
      w = 0;
      #1;
      while (!bus2.grant_valid && w < 6) begin cyc(); w++; end
      checks++; if (bus2.grant_valid !== 1'b1 || 8'(bus2.grant_idx) !== exp_q[0]) begin errors++; $display("FAIL n2_order: got %0d (valid %b) want %0d", bus2.grant_idx, bus2.grant_valid, exp_q[0]); end
      checks++; if (bus2.grant !== (2'b01 << exp_q[0])) begin errors++; $display("FAIL n2_onehot: got %b want idx %0d", bus2.grant, exp_q[0]); end
      bus2.tx_done = 1'b1;
      #1;
      checks++; if (bus2.ch_tx_done !== (2'b01 << exp_q[0])) begin errors++; $display("FAIL n2_done: got %b want idx %0d", bus2.ch_tx_done, exp_q[0]); end
      bus2.tx_done = 1'b0;
      bus2.req[bus2.grant_idx] = 1'b0;
      cyc();
      bus2.req = '1;
      void'(exp_q.pop_front());
    end
    for (int k = 0; k <= 8; k++) exp_q.push_back(8'(k % 8));
    while (exp_q.size() > 0) begin
      w = 0;
      #1;
      while (!bus8.grant_valid && w < 6) begin cyc(); w++; end
      checks++; if (bus8.grant_valid !== 1'b1 || 8'(bus8.grant_idx) !== exp_q[0]) begin errors++; $display("FAIL n8_order: got %0d (valid %b) want %0d", bus8.grant_idx, bus8.grant_valid, exp_q[0]); end
      checks++; if (bus8.grant !== (8'h01 << exp_q[0])) begin errors++; $display("FAIL n8_onehot: got %b want idx %0d", bus8.grant, exp_q[0]); end
      bus8.tx_done = 1'b1;
      #1;
      checks++; if (bus8.ch_tx_done !== (8'h01 << exp_q[0])) begin errors++; $display("FAIL n8_done: got %b want idx %0d", bus8.ch_tx_done, exp_q[0]); end
      bus8.tx_done = 1'b0;
      bus8.req[bus8.grant_idx] = 1'b0;
      cyc();
      bus8.req = '1;
      void'(exp_q.pop_front());
    end
    bus2.req = '0;
    bus8.req = '0;
    cyc();
  endtask

  task automatic test_random();
    int owner, gidx, last;
    bit drain, busy;
    logic [N-1:0]  e_grant, e_done;
    logic          e_ready;
    logic [DW-1:0] e_data;
    bus.req = '0;
    bus.ch_tx_ready = '0;
    bus.tx_done = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    owner = -1; gidx = 0; last = N - 1; drain = 0; busy = 0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) bus.req[i] = ~bus.req[i];
      for (int i = 0; i < N; i++) bus.ch_tx_ready[i] = ($urandom_range(2) == 0);
      bus.ch_tx_data = $urandom;
      bus.tx_done = ($urandom_range(4) == 0);
      #1;
      e_grant = '0; e_done = '0; e_ready = 1'b0; e_data = '0;
      if (owner >= 0) begin
        e_grant[owner] = 1'b1;
        e_done[owner]  = bus.tx_done;
        e_ready        = !drain && bus.ch_tx_ready[owner];
        e_data         = bus.ch_tx_data[owner*DW +: DW];
      end
      checks++; if (bus.grant !== e_grant) begin errors++; $display("FAIL rnd_grant t=%0d: got %b want %b", t, bus.grant, e_grant); end
      checks++; if (bus.grant_valid !== (owner >= 0)) begin errors++; $display("FAIL rnd_valid t=%0d: got %b want %b", t, bus.grant_valid, owner >= 0); end
      checks++; if (bus.grant_idx !== IW'(gidx)) begin errors++; $display("FAIL rnd_idx t=%0d: got %0d want %0d", t, bus.grant_idx, gidx); end
      checks++; if (bus.tx_ready !== e_ready) begin errors++; $display("FAIL rnd_ready t=%0d: got %b want %b", t, bus.tx_ready, e_ready); end
      checks++; if (bus.tx_data !== e_data) begin errors++; $display("FAIL rnd_data t=%0d: got %h want %h", t, bus.tx_data, e_data); end
      checks++; if (bus.ch_tx_done !== e_done) begin errors++; $display("FAIL rnd_done t=%0d: got %b want %b", t, bus.ch_tx_done, e_done); end
      // What the next edge should do, from the ownership rules
      if (owner < 0) begin
        for (int k = 1; k <= N; k++) if (owner < 0 && bus.req[(last + k) % N]) owner = (last + k) % N;
        if (owner >= 0) begin last = owner; gidx = owner; busy = 0; drain = 0; end
      end else if (!drain) begin
        if (bus.tx_done) busy = 0;
        else if (e_ready) busy = 1;
        if (!bus.req[owner]) begin
          if (busy) drain = 1;
          else owner = -1;
        end
      end else if (bus.tx_done) begin
        owner = -1; drain = 0; busy = 0;
      end
      cyc();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.req = '0;  bus.ch_tx_data = '0;  bus.ch_tx_ready = '0;  bus.tx_done = 1'b0;
    bus2.req = '0; bus2.ch_tx_data = '0; bus2.ch_tx_ready = '0; bus2.tx_done = 1'b0;
    bus8.req = '0; bus8.ch_tx_data = '0; bus8.ch_tx_ready = '0; bus8.tx_done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_drain();
    test_simultaneous();
    test_reset_mid();
    test_widths();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
